piso_tx: RTL and testbench

Parallel-in/serial-out transmitter: accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a serial line, with a per-bit valid and a start-of-word marker. It is the transmit end of the shift-register family: its serial output feeds a serial-in deserializer that rebuilds words for the parallel registers. A one-entry holding register lets consecutive words stream with no idle bit between them.

---
 rtl/piso_pkg.sv | 15 +
 rtl/bit_counter.sv | 25 ++
 rtl/piso_tx.sv | 124 ++++++++++++
 tb/tb_piso_tx.sv | 139 +++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the piso transmitter and its matching receiver:
// FSM state encoding and bit-counter sizing.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter width: clog2(w), never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Modulo-WIDTH bit counter with clear, enable and a last-bit flag.
module bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last
);

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= last ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with a one-word holding register so
// consecutive words stream with no idle bit between them.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ins,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg, hold;
    logic             hold_full;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;
    logic             ld_in, ld_hold, adv, wr_hold, go_idle;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign in_ready = !hold_full;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == SHIFT) || hold_full;
    // Counter sits at 0 exactly while the first bit of a word is on sout.
    assign sof      = sout_valid && (cnt == '0);

    bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (ld_in || ld_hold || go_idle),
        .en   (adv),
        .cnt  (cnt),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ld_in   = 1'b0;
        ld_hold = 1'b0;
        adv     = 1'b0;
        wr_hold = 1'b0;
        go_idle = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ld_in   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last) begin
                    adv     = 1'b1;
                    wr_hold = accept;
                end else if (hold_full) begin
                    ld_hold = 1'b1;
                end else if (accept) begin
                    ld_in   = 1'b1;
                end else begin
                    go_idle = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // sout is registered: the loaded word's first bit goes straight out,
    // the shifter keeps only the bits still to send.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg       <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
        end else begin
            if (ld_in) begin
                sout       <= first_bit(ins);
                sreg       <= drop_bit(ins);
                sout_valid <= 1'b1;
            end else if (ld_hold) begin
                sout       <= first_bit(hold);
                sreg       <= drop_bit(hold);
                sout_valid <= 1'b1;
                hold_full  <= 1'b0;
            end else if (adv) begin
                sout <= first_bit(sreg);
                sreg <= drop_bit(sreg);
            end else if (go_idle) begin
                sout       <= 1'b0;
                sout_valid <= 1'b0;
            end
            if (wr_hold) begin
                hold      <= ins;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first, LSB-first and WIDTH=1 instances checked every
// cycle against a bit-queue model of the expected serial stream.
module tb_piso_tx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] ins = '0;
    logic [2:0]   sout, vld, sof, busy, rdy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .ins(ins), .in_valid(in_valid), .in_ready(rdy[0]),
        .sout(sout[0]), .sout_valid(vld[0]), .sof(sof[0]), .busy(busy[0])
    );
    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .ins(ins), .in_valid(in_valid), .in_ready(rdy[1]),
        .sout(sout[1]), .sout_valid(vld[1]), .sof(sof[1]), .busy(busy[1])
    );
    piso_tx #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .ins(ins[0]), .in_valid(in_valid), .in_ready(rdy[2]),
        .sout(sout[2]), .sout_valid(vld[2]), .sof(sof[2]), .busy(busy[2])
    );

    // Model: queue of {sof, bit} still to appear on sout, plus the bit on sout now.
    logic [1:0] q0[$], q1[$], q2[$];
    logic [1:0] cur[3];
    logic [2:0] mv;
    logic       acc_main = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_rdy(input int k);
        case (k)
            0:       return q0.size() < W;
            1:       return q1.size() < W;
            default: return q2.size() < 1;
        endcase
    endfunction

    task automatic cycle();
        logic a0, a1, a2;
        a0 = !rst && in_valid && exp_rdy(0);
        a1 = !rst && in_valid && exp_rdy(1);
        a2 = !rst && in_valid && exp_rdy(2);
        acc_main = a0;
        @(posedge clk);
        if (rst) begin
            q0.delete(); q1.delete(); q2.delete();
        end else begin
            if (a0) for (int i = W-1; i >= 0; i--) q0.push_back({i == W-1, ins[i]});
            if (a1) for (int i = 0; i < W; i++)   q1.push_back({i == 0, ins[i]});
            if (a2) q2.push_back({1'b1, ins[0]});
        end
        mv = '0;
        if (q0.size() > 0) begin cur[0] = q0.pop_front(); mv[0] = 1'b1; end
        if (q1.size() > 0) begin cur[1] = q1.pop_front(); mv[1] = 1'b1; end
        if (q2.size() > 0) begin cur[2] = q2.pop_front(); mv[2] = 1'b1; end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d%0d_valid", k), 32'(vld[k]),  32'(mv[k]));
            chk($sformatf("d%0d_sof", k),   32'(sof[k]),  32'(mv[k] && cur[k][1]));
            chk($sformatf("d%0d_busy", k),  32'(busy[k]), 32'(mv[k]));
            chk($sformatf("d%0d_ready", k), 32'(rdy[k]),  32'(exp_rdy(k)));
            if (mv[k]) chk($sformatf("d%0d_sout", k), 32'(sout[k]), 32'(cur[k][0]));
        end
    endtask

    // Present a word and keep it stable until the WIDTH=4 instances take it.
    task automatic push_word(input logic [W-1:0] w);
        int n = 0;
        ins = w;
        in_valid = 1'b1;
        do begin
            cycle();
            n++;
        end while (!acc_main && n < 40);
        if (!acc_main) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        mv = '0;
        rst = 1'b1;
        repeat (2) cycle();
        chk("rst_sout", 32'(sout), 32'd0);
        chk("rst_ready", 32'(rdy), 32'h7);
        rst = 1'b0;
        repeat (10) begin
            cycle();
            chk("idle_sout", 32'(sout), 32'd0);
        end

        push_word(4'b1010); idle(6);
        push_word(4'b1100); push_word(4'b0111); idle(10);
        push_word(4'b1010); push_word(4'b1100); push_word(4'b0111); idle(14);
        push_word(4'b0001); idle(6);

        // Reset with two bits of 1010 sent and 1100 in the holding register.
        push_word(4'b1010); push_word(4'b1100);
        rst = 1'b1; ins = 4'b0111; in_valid = 1'b1;
        cycle();
        rst = 1'b0; in_valid = 1'b0;
        chk("midrst_valid", 32'(vld), 32'd0);
        chk("midrst_ready", 32'(rdy), 32'h7);
        push_word(4'b0111); idle(6);

        repeat (600) begin
            if (!in_valid || acc_main) begin
                in_valid = ($urandom_range(0, 3) != 0);
                ins = W'($urandom);
            end
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
